// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator side of the LC-3 MAR/MDR memory path; sequences one read or write per request.
// Optional feature macro: MEM_ACV_CHECK_EN (user-mode access-control violation check).
module mem_access_ctrl #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        priv,
  input  logic [15:0] MDROut,
  output logic [15:0] bus_out,
  output logic        bus_drive,
  output logic        ldMAR,
  output logic        ldMDR,
  output logic        selMDR,
  output logic        memWE,
  output logic [15:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        acv,
  output logic [2:0]  dbg_state
);

  // Handshake: req is sampled only in IDLE and the request fields are latched on
  // that edge; done pulses for one cycle (rdata/acv valid with it). A req still
  // high in the idle cycle after done starts the next access.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAR   = 3'd1,
    S_RWAIT = 3'd2,
    S_RMDR  = 3'd3,
    S_CAPT  = 3'd4,
    S_WMDR  = 3'd5,
    S_WWE   = 3'd6,
    S_RESP  = 3'd7
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        acv_q, acv_d;
  logic        acv_hit;

`ifdef MEM_ACV_CHECK_EN
  assign acv_hit = priv && ((addr < 16'h3000) || (addr >= 16'hFE00));
`else
  logic priv_unused;
  assign priv_unused = priv;
  assign acv_hit     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      acv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      acv_q   <= acv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    acv_d   = acv_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          wr_d    = wr;
          addr_d  = addr;
          wdata_d = wdata;
          acv_d   = acv_hit;
          state_d = acv_hit ? S_RESP : S_MAR;
        end
      end
      S_MAR: begin
        if (wr_q) begin
          state_d = S_WMDR;
        end else begin
          cnt_d   = LAT_M1;
          state_d = S_RWAIT;
        end
      end
      // Stays exactly MEM_LATENCY cycles; the counter stops at zero.
      S_RWAIT: begin
        if (cnt_q == 4'd0) state_d = S_RMDR;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RMDR: state_d = S_CAPT;
      S_CAPT: begin
        rdata_d = MDROut;
        state_d = S_RESP;
      end
      S_WMDR: state_d = S_WWE;
      S_WWE:  state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory-side strobes depend on state only.
  always_comb begin
    bus_out   = 16'h0000;
    bus_drive = 1'b0;
    ldMAR     = 1'b0;
    ldMDR     = 1'b0;
    selMDR    = 1'b0;
    memWE     = 1'b0;
    case (state_q)
      S_MAR: begin
        bus_out   = addr_q;
        bus_drive = 1'b1;
        ldMAR     = 1'b1;
      end
      S_RMDR: begin
        selMDR = 1'b1;
        ldMDR  = 1'b1;
      end
      S_WMDR: begin
        bus_out   = wdata_q;
        bus_drive = 1'b1;
        ldMDR     = 1'b1;
      end
      S_WWE:   memWE = 1'b1;
      default: ;
    endcase
  end

  assign done      = (state_q == S_RESP);
  assign acv       = done && acv_q;
  assign busy      = (state_q != S_IDLE);
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (MEM_LATENCY 1 and 3), each with a small Memory
// environment, checked every cycle against a per-access timeline model.
module tb_mem_access_ctrl;

  localparam int K_READ  = 0;
  localparam int K_WRITE = 1;
  localparam int K_ACV   = 2;

`ifdef MEM_ACV_CHECK_EN
  localparam int          ACV_LAT = 1;
  localparam logic [15:0] ACV_RD  = 16'h1234;
`else
  localparam int          ACV_LAT = 5;
  localparam logic [15:0] ACV_RD  = 16'h0BAD;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req [2];
  logic        wr [2];
  logic        priv [2];
  logic [15:0] addr [2];
  logic [15:0] wdata [2];
  logic [15:0] bus_out [2];
  logic [15:0] rdata [2];
  logic        bus_drive [2];
  logic        ld_mar [2];
  logic        ld_mdr [2];
  logic        sel_mdr [2];
  logic        mem_we [2];
  logic        done [2];
  logic        busy [2];
  logic        acv [2];
  logic [2:0]  dbg [2];

  // Memory environment
  logic [15:0] mem [2][65536];
  logic [15:0] pipe [2][4];
  logic [15:0] mar [2];
  logic [15:0] mdr [2];
  logic        pl_en [2];
  logic [15:0] pl_addr [2];
  logic [15:0] pl_data [2];

  // Reference model
  logic [15:0] ref_mem [2][65536];
  bit          m_act [2] = '{1'b0, 1'b0};
  int          m_k [2];
  int          m_len [2];
  int          m_kind [2];
  logic [15:0] m_addr [2];
  logic [15:0] m_wdata [2];
  logic [15:0] m_rd_new [2];
  logic [15:0] m_rd_old [2] = '{16'h0, 16'h0};

  logic [15:0] pool [16];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic bit acv_rule(input logic p, input logic [15:0] a);
`ifdef MEM_ACV_CHECK_EN
    return p && ((a < 16'h3000) || (a >= 16'hFE00));
`else
    return (p && 1'b0) || (a == 16'h0 && 1'b0);
`endif
  endfunction

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_access_ctrl #(.MEM_LATENCY((g == 0) ? 1 : 3)) u_dut (
        .clk       (clk),
        .reset     (rst),
        .req       (req[g]),
        .wr        (wr[g]),
        .addr      (addr[g]),
        .wdata     (wdata[g]),
        .priv      (priv[g]),
        .MDROut    (mdr[g]),
        .bus_out   (bus_out[g]),
        .bus_drive (bus_drive[g]),
        .ldMAR     (ld_mar[g]),
        .ldMDR     (ld_mdr[g]),
        .selMDR    (sel_mdr[g]),
        .memWE     (mem_we[g]),
        .rdata     (rdata[g]),
        .done      (done[g]),
        .busy      (busy[g]),
        .acv       (acv[g]),
        .dbg_state (dbg[g])
      );
    end
  endgenerate

  // Memory block: MAR/MDR registers and a RAM whose output is valid lat_of(g) edges after MAR load.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (ld_mar[g]) mar[g] <= bus_drive[g] ? bus_out[g] : 16'hDEAD;
      if (ld_mdr[g]) mdr[g] <= sel_mdr[g] ? pipe[g][lat_of(g) - 1] : (bus_drive[g] ? bus_out[g] : 16'hDEAD);
      if (mem_we[g]) mem[g][mar[g]] <= mdr[g];
      if (pl_en[g]) mem[g][pl_addr[g]] <= pl_data[g];
      pipe[g][0] <= mem[g][mar[g]];
      for (int i = 1; i < 4; i++) pipe[g][i] <= pipe[g][i - 1];
    end
  end

  // Model: each accepted access is a timeline of m_len cycles; cycle 1 follows the accept edge.
  always @(posedge clk or posedge rst) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        m_act[g]    = 1'b0;
        m_rd_old[g] = 16'h0000;
      end else begin
        if (pl_en[g]) ref_mem[g][pl_addr[g]] = pl_data[g];
        if (m_act[g]) begin
          if (m_k[g] == m_len[g]) begin
            m_act[g] = 1'b0;
            if (m_kind[g] == K_READ) m_rd_old[g] = m_rd_new[g];
          end else begin
            m_k[g] = m_k[g] + 1;
          end
        end else if (req[g]) begin
          m_act[g]   = 1'b1;
          m_k[g]     = 1;
          m_addr[g]  = addr[g];
          m_wdata[g] = wdata[g];
          if (acv_rule(priv[g], addr[g])) begin
            m_kind[g] = K_ACV;
            m_len[g]  = 1;
          end else if (wr[g]) begin
            m_kind[g] = K_WRITE;
            m_len[g]  = 4;
            ref_mem[g][addr[g]] = wdata[g];
          end else begin
            m_kind[g]   = K_READ;
            m_len[g]    = 4 + lat_of(g);
            m_rd_new[g] = ref_mem[g][addr[g]];
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Strobe vector bits: {busy, done, acv, ldMAR, ldMDR, selMDR, memWE, bus_drive}
  task automatic compare_all();
    for (int g = 0; g < 2; g++) begin
      logic [7:0]  exp_s;
      logic [7:0]  act_s;
      logic [15:0] exp_bus;
      logic [15:0] exp_rd;
      int k;
      int l;
      exp_s   = 8'h00;
      exp_bus = 16'h0000;
      exp_rd  = m_rd_old[g];
      k       = m_k[g];
      l       = lat_of(g);
      if (m_act[g]) begin
        exp_s[7] = 1'b1;
        if (m_kind[g] == K_ACV) begin
          exp_s[6:5] = 2'b11;
        end else if (m_kind[g] == K_WRITE) begin
          if (k == 1)      begin exp_s[4] = 1'b1; exp_s[0] = 1'b1; exp_bus = m_addr[g]; end
          else if (k == 2) begin exp_s[3] = 1'b1; exp_s[0] = 1'b1; exp_bus = m_wdata[g]; end
          else if (k == 3) exp_s[1] = 1'b1;
          else             exp_s[6] = 1'b1;
        end else begin
          if (k == 1)          begin exp_s[4] = 1'b1; exp_s[0] = 1'b1; exp_bus = m_addr[g]; end
          else if (k == 2 + l) begin exp_s[3] = 1'b1; exp_s[2] = 1'b1; end
          else if (k == 4 + l) begin exp_s[6] = 1'b1; exp_rd = m_rd_new[g]; end
        end
      end
      act_s = {busy[g], done[g], acv[g], ld_mar[g], ld_mdr[g], sel_mdr[g], mem_we[g], bus_drive[g]};
      check($sformatf("strobes%0d", g), 32'(act_s), 32'(exp_s));
      if (exp_s[0]) check($sformatf("bus_out%0d", g), 32'(bus_out[g]), 32'(exp_bus));
      check($sformatf("rdata%0d", g), 32'(rdata[g]), 32'(exp_rd));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  task automatic preload(input int g, input logic [15:0] a, input logic [15:0] d);
    pl_en[g]   = 1'b1;
    pl_addr[g] = a;
    pl_data[g] = d;
    tick();
    pl_en[g] = 1'b0;
  endtask

  task automatic access(input int g, input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic p, input int exp_lat, input string tag, output logic [15:0] rd);
    int  n;
    bit  got;
    req[g] = 1'b1; wr[g] = w; addr[g] = a; wdata[g] = d; priv[g] = p;
    n = 0;
    got = 0;
    while (!got && n < 40) begin
      tick();
      n++;
      req[g] = 1'b0;
      if (done[g]) got = 1;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    rd = rdata[g];
    tick();
  endtask

  initial begin
    logic [15:0] rd;
    int nmar;
    int ndone;
    pool = '{16'h3000, 16'h3001, 16'h4000, 16'hFFFF, 16'h0200, 16'h2FFF, 16'hFDFF, 16'hFE00,
             16'h0000, 16'h1234, 16'h8000, 16'hABCD, 16'h3002, 16'h7FFF, 16'hFFFE, 16'h5555};
    for (int g = 0; g < 2; g++) begin
      req[g] = 1'b0; wr[g] = 1'b0; priv[g] = 1'b0; addr[g] = 16'h0; wdata[g] = 16'h0;
      pl_en[g] = 1'b0; pl_addr[g] = 16'h0; pl_data[g] = 16'h0;
    end
    #1 rst = 1'b1;
    tick();
    check("reset_rdata0", 32'(rdata[0]), 32'h0);
    check("reset_busy1", 32'(busy[1]), 32'h0);
    tick();
    rst = 1'b0;
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 16; i++) preload(g, pool[i], 16'($urandom));
    preload(0, 16'h3000, 16'h1234);
    preload(0, 16'h0200, 16'h0BAD);

    // Basic read at latency 1
    access(0, 1'b0, 16'h3000, 16'h0, 1'b0, 5, "rd3000", rd);
    check("rd3000_data", 32'(rd), 32'h1234);
    // Write then readback
    access(0, 1'b1, 16'h3001, 16'hBEEF, 1'b0, 4, "wr3001", rd);
    access(0, 1'b0, 16'h3001, 16'h0, 1'b0, 5, "rd3001", rd);
    check("rd3001_data", 32'(rd), 32'hBEEF);

    // A request raised during RWAIT is ignored
    nmar = 0; ndone = 0;
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 16'h4000; priv[0] = 1'b0;
    tick(); nmar += int'(ld_mar[0]); ndone += int'(done[0]); req[0] = 1'b0;
    tick(); nmar += int'(ld_mar[0]); ndone += int'(done[0]); req[0] = 1'b1; addr[0] = 16'h3000;
    tick(); nmar += int'(ld_mar[0]); ndone += int'(done[0]); req[0] = 1'b0;
    repeat (10) begin
      tick(); nmar += int'(ld_mar[0]); ndone += int'(done[0]);
    end
    check("busy_req_done_count", 32'(ndone), 32'd1);
    check("busy_req_ldmar_count", 32'(nmar), 32'd1);

    // Reset during RWAIT aborts the access immediately
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 16'h3000;
    tick(); req[0] = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check("rst_strobes", 32'({busy[0], done[0], acv[0], ld_mar[0], ld_mdr[0], sel_mdr[0], mem_we[0], bus_drive[0]}), 32'h0);
    check("rst_rdata", 32'(rdata[0]), 32'h0);
    check("rst_bus_out", 32'(bus_out[0]), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    access(0, 1'b0, 16'h3000, 16'h0, 1'b0, 5, "rd_after_rst", rd);
    check("rd_after_rst_data", 32'(rd), 32'h1234);

    // User-mode access to a protected address, then the same as supervisor
    access(0, 1'b0, 16'h0200, 16'h0, 1'b1, ACV_LAT, "acv_user", rd);
    check("acv_user_rdata", 32'(rd), 32'(ACV_RD));
    access(0, 1'b0, 16'h0200, 16'h0, 1'b0, 5, "acv_super", rd);
    check("acv_super_rdata", 32'(rd), 32'h0BAD);

    // Latency 3, top address
    preload(1, 16'hFFFF, 16'hA5A5);
    access(1, 1'b0, 16'hFFFF, 16'h0, 1'b0, 7, "lat3_rdffff", rd);
    check("lat3_rdffff_data", 32'(rd), 32'hA5A5);
    access(1, 1'b1, 16'hFFFF, 16'h5A5A, 1'b0, 4, "lat3_wrffff", rd);
    access(1, 1'b0, 16'hFFFF, 16'h0, 1'b0, 7, "lat3_rdback", rd);
    check("lat3_rdback_data", 32'(rd), 32'h5A5A);

    // Randomized traffic on both instances
    for (int c = 0; c < 600; c++) begin
      for (int g = 0; g < 2; g++) begin
        req[g]   = ($urandom_range(0, 3) != 0);
        wr[g]    = 1'($urandom_range(0, 1));
        addr[g]  = pool[$urandom_range(0, 15)];
        wdata[g] = 16'($urandom);
        priv[g]  = 1'($urandom_range(0, 1));
      end
      tick();
    end
    req[0] = 1'b0;
    req[1] = 1'b0;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the LC-3 MAR/MDR memory path. Sequences one read or one write per request.
- Drives the shared bus value and the ldMAR / ldMDR / selMDR / memWE strobes into the Memory block. Captures MDROut for reads.
- Sits between the control-unit FSM (single-word request/done handshake) and Memory.
- Hides Memory's synchronous RAM latency behind a fixed, parameterised wait count.

Parameters:
- MEM_LATENCY, 1, clock edges from MAR load until memOut is valid at the MDR mux; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  1  access request; sampled only in IDLE
- wr  input  1  1 = write, 0 = read; latched with req
- addr  input  16  word address; latched with req
- wdata  input  16  write data; latched with req
- priv  input  1  1 = user mode, 0 = supervisor; latched with req
- MDROut  input  16  Memory MDR register output
- bus_out  output  16  value driven onto Bus toward Memory
- bus_drive  output  1  1 while bus_out must be gated onto Bus
- ldMAR  output  1  MAR load strobe
- ldMDR  output  1  MDR load strobe
- selMDR  output  1  MDR mux select: 1 = memOut, 0 = Bus
- memWE  output  1  RAM write enable
- rdata  output  16  registered read data
- done  output  1  one-cycle completion pulse
- busy  output  1  state != IDLE
- acv  output  1  access-control violation, valid with done

Behaviour:
- Reset (async, immediate): state = IDLE; wait counter = 0; latched request regs = 0; all strobes = 0; bus_out = 0; bus_drive = 0; rdata = 0x0000; done = 0; acv = 0.
- Reset mid-access aborts the access. No strobe may remain high after reset asserts.
- Strobes are decoded from state only (Moore outputs), not from inputs.
- IDLE: on req = 1, latch wr/addr/wdata/priv and go to MAR. Otherwise stay.
- MAR: bus_out = addr_q; bus_drive = 1; ldMAR = 1.
  - Read: go to RWAIT and load the counter with MEM_LATENCY-1.
  - Write: go to WMDR.
- RWAIT: all strobes 0. Decrement the counter; on 0 go to RMDR.
  - Occupies exactly MEM_LATENCY cycles.
- RMDR: selMDR = 1; ldMDR = 1; bus_drive = 0. Go to CAPT.
- CAPT: rdata <= MDROut at the edge. Go to RESP.
- WMDR: bus_out = wdata_q; bus_drive = 1; selMDR = 0; ldMDR = 1. Go to WWE.
- WWE: memWE = 1 for exactly one cycle; MAR and MDR already hold addr/wdata. Go to RESP.
- RESP: done = 1. Go to IDLE.
- Latency, with the accept edge as cycle 0:
  - Read: done in cycle 4+MEM_LATENCY (cycle 5 at default).
  - Write: done in cycle 4.
- Accesses never overlap. req while busy is ignored and not queued.
- The requester deasserts req in the cycle after done unless it is starting a new access. A held req restarts on the next IDLE cycle, giving a one-cycle bubble.
- rdata changes only in CAPT. Writes and ACV aborts leave it unchanged.
- Address and data are 16-bit; no wrap handling is needed. 0xFFFF is a legal address.
- The counter is 4 bits and never underflows.

Optional Feature:
- Macro: MEM_ACV_CHECK_EN.
- Defined:
  - In IDLE, if req = 1 and priv = 1 and (addr < 0x3000 or addr >= 0xFE00), go directly to RESP.
  - In RESP, done = 1 and acv = 1. No ldMAR/ldMDR/memWE is issued; done comes in cycle 1.
  - acv is 0 in all other cycles.
  - Supervisor accesses (priv = 0) are never flagged.
- Undefined: acv is tied to 0, and every request follows the normal path regardless of priv.

Test Plan:
1. Preload mem[0x3000] = 0x1234, MEM_LATENCY = 1, read 0x3000 -> ldMAR only in cycle 1, ldMDR+selMDR only in cycle 3, done in cycle 5, rdata = 0x1234, busy high cycles 1-5.
2. Write 0x3001 = 0xBEEF, then read 0x3001 -> write done in cycle 4; memWE high only in cycle 3, with bus_out = 0xBEEF in cycle 2; readback rdata = 0xBEEF.
3. Pulse req during RWAIT of a read of 0x4000 -> second request ignored; exactly one done; no extra ldMAR pulse.
4. Assert reset during RWAIT -> all strobes and busy go to 0 before the next edge, rdata = 0. After release, a read of 0x3000 returns 0x1234 normally.
5. MEM_LATENCY = 3, read 0xFFFF preloaded with 0xA5A5 -> done in cycle 7, rdata = 0xA5A5.
6. With MEM_ACV_CHECK_EN: priv = 1, read 0x0200 -> done = acv = 1 in cycle 1, no strobes, rdata unchanged. Same request with priv = 0 -> normal read with acv = 0.
